// File: rtl/spu32_cpu_shift_sequencer_if.sv
// Handshake/data bundle for the multi-cycle shift sequencer.
//   I_stb         start request, sampled only while O_busy=0
//   I_data        operand to shift
//   I_shift       shift amount 0..31
//   I_signextend  1 = arithmetic right shift
//   I_leftshift   1 = logical left shift
//   O_busy        operation in progress
//   O_done        one-cycle pulse, O_data holds the final result
//   O_data        working/result register
// master: issue side (ALU issue logic); slave: the sequencer.
interface spu32_cpu_shift_sequencer_if;
    logic        I_stb;
    logic [31:0] I_data;
    logic [4:0]  I_shift;
    logic        I_signextend;
    logic        I_leftshift;
    logic        O_busy;
    logic        O_done;
    logic [31:0] O_data;

    modport master (
        output I_stb, I_data, I_shift, I_signextend, I_leftshift,
        input  O_busy, O_done, O_data
    );

    modport slave (
        input  I_stb, I_data, I_shift, I_signextend, I_leftshift,
        output O_busy, O_done, O_data
    );
endinterface

// File: rtl/spu32_cpu_shift_sequencer.sv
// Multi-cycle barrel-shift controller. A 0..31 bit shift is split into
// chunks of at most STEP_MAX bits, one chunk per clock, so only a small
// per-cycle shifter is needed.
//   I_clk    clock, rising edge
//   I_reset  asynchronous active-high reset; drops any operation in flight
//   bus      slave side of spu32_cpu_shift_sequencer_if (start/busy/done,
//            operand, amount, mode, result)
// STEP_MAX: 1,2,4,8,16 or 32 (32 = single-cycle operation).
// All outputs come straight from registers.
module spu32_cpu_shift_sequencer #(
    parameter int unsigned STEP_MAX = 8
) (
    input logic                          I_clk,
    input logic                          I_reset,
    spu32_cpu_shift_sequencer_if.slave   bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // 6-bit so STEP_MAX=32 is representable in the chunk comparison.
    localparam logic [5:0] STEP_LIM = 6'(STEP_MAX);

    state_t      state_q;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic [4:0]  rem_q;
    logic [4:0]  rem_d;
    logic        left_q;
    logic        sext_q;
    logic        busy_q;
    logic        done_q;

    logic [5:0]  rem_w;
    logic [5:0]  step_w;
    logic [5:0]  rem_left_w;
    logic        last_w;
    logic        fill_w;
    logic [31:0] fill_mask_w;

    always_comb begin
        rem_w       = {1'b0, rem_q};
        step_w      = (rem_w > STEP_LIM) ? STEP_LIM : rem_w;
        rem_left_w  = rem_w - step_w;
        last_w      = (rem_left_w == '0);
        rem_d       = rem_left_w[4:0];
        // Bit 31 keeps the sign through every partial step, so chained
        // chunks compose to the same result as one full arithmetic shift.
        fill_w      = sext_q & data_q[31];
        fill_mask_w = ~(32'hFFFF_FFFF >> step_w);
        if (left_q) begin
            data_d = data_q << step_w;
        end else begin
            data_d = (data_q >> step_w) | ({32{fill_w}} & fill_mask_w);
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            sext_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.I_stb) begin
                        data_q  <= bus.I_data;
                        rem_q   <= bus.I_shift;
                        left_q  <= bus.I_leftshift;
                        // Left + signextend degenerates to a plain SLL.
                        sext_q  <= bus.I_signextend & ~bus.I_leftshift;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q <= data_d;
                    rem_q  <= rem_d;
                    if (last_w) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O_busy = busy_q;
    assign bus.O_done = done_q;
    assign bus.O_data = data_q;

endmodule
